// File: rtl/char_seq_ctrl_if.sv
// Bundle between the character sequencer and its host: control inputs, the
// ROM read channel and the display-side outputs.
interface char_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic       loop_en;
    logic [3:0] last_slot;

    // ROM channel: rd_req stays high until rd_ack is sampled high; rd_data is
    // captured on that ack cycle; an rd_ack seen while rd_req is low is ignored.
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;

    logic [7:0] count;
    logic [3:0] slot;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    modport master (
        output start, stop, hold, loop_en, last_slot, rd_ack, rd_data,
        input  rd_req, rd_addr, count, slot, bit_out, bit_valid, busy, done, dbg_state
    );

    modport slave (
        input  start, stop, hold, loop_en, last_slot, rd_ack, rd_data,
        output rd_req, rd_addr, count, slot, bit_out, bit_valid, busy, done, dbg_state
    );
endinterface

// File: rtl/char_seq_ctrl.sv
// Character sequencer: fetches one ROM byte per slot and shifts it out MSB-first,
// producing the bit-time count {0, slot, bit} for the display datapath.
module char_seq_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic            sysclk,
    input  logic            rst_n,
    char_seq_ctrl_if.slave  bus
);
    localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [3:0]    r_slot;
    logic [2:0]    r_bit;
    logic [7:0]    r_shreg;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_last;
    logic          r_rd_req;
    logic          r_bit_valid;
    logic          r_busy;
    logic          r_done;

    logic          w_tick;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_slot      <= 4'd0;
            r_bit       <= 3'd0;
            r_shreg     <= 8'd0;
            r_presc     <= '0;
            r_last      <= 4'd0;
            r_rd_req    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (bus.stop) begin
            // Abort beats start, ack and terminal count; an acked byte is dropped.
            r_state     <= S_IDLE;
            r_slot      <= 4'd0;
            r_bit       <= 3'd0;
            r_shreg     <= 8'd0;
            r_presc     <= '0;
            r_rd_req    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_slot <= 4'd0;
                    r_bit  <= 3'd0;
                    if (bus.start) begin
                        r_last   <= bus.last_slot;
                        r_state  <= S_FETCH;
                        r_rd_req <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (bus.rd_ack) begin
                        r_shreg     <= bus.rd_data;
                        r_bit       <= 3'd0;
                        r_presc     <= '0;
                        r_rd_req    <= 1'b0;
                        r_bit_valid <= 1'b1;
                        r_state     <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!bus.hold) begin
                        if (!w_tick) begin
                            r_presc <= r_presc + PW'(1);
                        end else begin
                            r_presc <= '0;
                            if (r_bit != 3'd7) begin
                                r_shreg <= {r_shreg[6:0], 1'b0};
                                r_bit   <= r_bit + 3'd1;
                            end else if (r_slot < r_last) begin
                                r_slot      <= r_slot + 4'd1;
                                r_bit       <= 3'd0;
                                r_rd_req    <= 1'b1;
                                r_bit_valid <= 1'b0;
                                r_state     <= S_FETCH;
                            end else if (bus.loop_en) begin
                                r_slot      <= 4'd0;
                                r_bit       <= 3'd0;
                                r_rd_req    <= 1'b1;
                                r_bit_valid <= 1'b0;
                                r_state     <= S_FETCH;
                            end else begin
                                // Count stays at its final value through DONE.
                                r_bit_valid <= 1'b0;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_slot  <= 4'd0;
                    r_bit   <= 3'd0;
                    r_shreg <= 8'd0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_req    = r_rd_req;
    assign bus.rd_addr   = r_slot;
    assign bus.count     = {1'b0, r_slot, r_bit};
    assign bus.slot      = r_slot;
    assign bus.bit_out   = r_shreg[7];
    assign bus.bit_valid = r_bit_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_char_seq_ctrl.sv
// Directed bench for char_seq_ctrl with TICK_DIV=4: scenario tasks with
// hand-computed expectations and a small ROM responder with programmable wait.
module tb_char_seq_ctrl;
    localparam int TICK_DIV = 4;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic       rom_en     = 1'b1;
    logic       rom_ack    = 1'b0;
    logic [7:0] rom_data   = 8'd0;
    logic       man_ack    = 1'b0;
    logic [7:0] man_data   = 8'd0;
    logic [4:0] slow_addr  = 5'h1f;
    int         slow_delay = 0;

    logic [7:0] exp_q[$];

    char_seq_ctrl_if ifc();

    char_seq_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (ifc)
    );

    assign ifc.rd_ack  = rom_en ? rom_ack  : man_ack;
    assign ifc.rd_data = rom_en ? rom_data : man_data;

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (ifc.done === 1'b1) done_cnt++;

    function automatic logic [7:0] rom_byte(input logic [3:0] a);
        return 8'hA5 ^ {a, a};
    endfunction

    function automatic logic [22:0] outs();
        return {ifc.dbg_state, ifc.rd_req, ifc.rd_addr, ifc.count, ifc.slot,
                ifc.bit_out, ifc.bit_valid, ifc.busy, ifc.done};
    endfunction

    // ROM responder: acks an outstanding request after 0 wait cycles, or
    // slow_delay cycles for slow_addr.
    initial begin : rom_model
        int wcnt;
        int need;
        wcnt = 0;
        forever begin
            @(posedge sysclk); #1;
            if (ifc.rd_req === 1'b1 && !rom_ack) begin
                need = ({1'b0, ifc.rd_addr} == slow_addr) ? slow_delay : 0;
                if (wcnt >= need) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_byte(ifc.rd_addr);
                    wcnt     = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                rom_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    task automatic step();
        @(posedge sysclk); #1;
    endtask

    task automatic pulse_start(input logic [3:0] ls, input logic le);
        ifc.last_slot = ls;
        ifc.loop_en   = le;
        ifc.start     = 1'b1;
        step();
        ifc.start     = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit to);
        to = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (ifc.done === 1'b1) begin
                to = 1'b0;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.start = 1'b1; ifc.stop = 1'b0; ifc.hold = 1'b1;
        ifc.loop_en = 1'b1; ifc.last_slot = 4'hf;
        repeat (4) begin
            step();
            ifc.start = ~ifc.start;
            ifc.stop  = ~ifc.stop;
        end
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL reset_held: got %0h want 0", outs()); end
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.hold = 1'b0;
        ifc.loop_en = 1'b0; ifc.last_slot = 4'd0;
        rst_n = 1'b1;
        repeat (5) step();
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL reset_idle: got %0h want 0", outs()); end
    endtask

    task automatic test_single_slot();
        int d0;
        logic [7:0] pat;
        logic [7:0] e;
        d0  = done_cnt;
        pat = 8'hA5;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, pat[7-i]});
        pulse_start(4'd0, 1'b0);
        total++;
        if (ifc.rd_req !== 1'b1 || ifc.rd_addr !== 4'd0 || ifc.busy !== 1'b1) begin
            bad++; $display("FAIL req_rise: got req=%b addr=%0d busy=%b want 1 0 1", ifc.rd_req, ifc.rd_addr, ifc.busy);
        end
        step();
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            for (int c = 0; c < TICK_DIV; c++) begin
                total++;
                if ({ifc.bit_valid, ifc.bit_out} !== {1'b1, e[0]} || ifc.count !== 8'(i)) begin
                    bad++;
                    $display("FAIL a5_bit%0d_c%0d: got v=%b b=%b cnt=%0d want v=1 b=%b cnt=%0d",
                             i, c, ifc.bit_valid, ifc.bit_out, ifc.count, e[0], i);
                end
                step();
            end
        end
        total++;
        if (ifc.done !== 1'b1 || ifc.busy !== 1'b0 || ifc.count !== 8'd7) begin
            bad++; $display("FAIL a5_done: got done=%b busy=%b cnt=%0d want 1 0 7", ifc.done, ifc.busy, ifc.count);
        end
        step();
        total++;
        if (ifc.done !== 1'b0 || ifc.count !== 8'd0 || done_cnt - d0 != 1) begin
            bad++; $display("FAIL a5_idle: got done=%b cnt=%0d pulses=%0d want 0 0 1", ifc.done, ifc.count, done_cnt - d0);
        end
    endtask

    task automatic test_full_run();
        int d0;
        int fetches;
        int skips;
        bit to;
        logic prev_req;
        logic [7:0] prev_cnt;
        logic [7:0] max_cnt;
        logic [7:0] expa;
        d0 = done_cnt; fetches = 0; skips = 0; to = 1'b1;
        prev_req = 1'b0; prev_cnt = 8'd0; max_cnt = 8'd0;
        exp_q.delete();
        for (int a = 0; a < 16; a++) exp_q.push_back(8'(a));
        pulse_start(4'd15, 1'b0);
        for (int n = 0; n < 1500; n++) begin
            if (ifc.rd_req === 1'b1 && !prev_req) begin
                fetches++;
                expa = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hff;
                total++;
                if ({4'h0, ifc.rd_addr} !== expa) begin
                    bad++; $display("FAIL addr_order: got %0d want %0d", ifc.rd_addr, expa);
                end
            end
            if (ifc.count > max_cnt) max_cnt = ifc.count;
            if (ifc.count !== prev_cnt && ifc.count !== prev_cnt + 8'd1) skips++;
            prev_req = ifc.rd_req;
            prev_cnt = ifc.count;
            if (ifc.done === 1'b1) begin
                to = 1'b0;
                break;
            end
            step();
        end
        total++;
        if (to) begin bad++; $display("FAIL full_timeout: got no done want done"); end
        total++;
        if (fetches != 16) begin bad++; $display("FAIL full_fetches: got %0d want 16", fetches); end
        total++;
        if (max_cnt !== 8'd127 || ifc.count !== 8'd127) begin
            bad++; $display("FAIL full_max: got max=%0d end=%0d want 127", max_cnt, ifc.count);
        end
        total++;
        if (skips != 0) begin bad++; $display("FAIL full_skip: got %0d want 0", skips); end
        step();
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_ack_delay();
        int d0;
        int n_req;
        int herr;
        bit found;
        bit to;
        logic [7:0] b;
        d0 = done_cnt; found = 1'b0; n_req = 0; herr = 0;
        slow_addr = 5'd1; slow_delay = 3;
        b = rom_byte(4'd1);
        pulse_start(4'd1, 1'b0);
        for (int n = 0; n < 100; n++) begin
            if (ifc.rd_req === 1'b1 && ifc.rd_addr === 4'd1) begin found = 1'b1; break; end
            step();
        end
        total++;
        if (!found || ifc.count !== 8'd8) begin
            bad++; $display("FAIL slow_req: got found=%b cnt=%0d want 1 8", found, ifc.count);
        end
        while (ifc.rd_req === 1'b1 && n_req < 20) begin
            if (ifc.count !== 8'd8 || ifc.bit_valid !== 1'b0) herr++;
            n_req++;
            step();
        end
        total++;
        if (n_req != 4 || herr != 0) begin bad++; $display("FAIL slow_req_len: got len=%0d err=%0d want 4 0", n_req, herr); end
        total++;
        if (ifc.bit_valid !== 1'b1 || ifc.bit_out !== b[7] || ifc.count !== 8'd8) begin
            bad++; $display("FAIL slow_first_bit: got v=%b b=%b cnt=%0d want 1 %b 8", ifc.bit_valid, ifc.bit_out, ifc.count, b[7]);
        end
        wait_done(200, to);
        step();
        total++;
        if (to || done_cnt - d0 != 1) begin bad++; $display("FAIL slow_done: got to=%b pulses=%0d want 0 1", to, done_cnt - d0); end
        slow_addr = 5'h1f; slow_delay = 0;
    endtask

    task automatic test_loop();
        int d0;
        bit found;
        bit to;
        d0 = done_cnt;
        pulse_start(4'd2, 1'b1);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ifc.count === 8'd23) begin found = 1'b1; break; end
            step();
        end
        total++;
        if (!found) begin bad++; $display("FAIL loop_reach23: got no 23 want 23"); end
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (ifc.rd_req === 1'b1) begin found = 1'b1; break; end
            step();
        end
        total++;
        if (!found || ifc.rd_addr !== 4'd0 || ifc.count !== 8'd0 || ifc.slot !== 4'd0) begin
            bad++; $display("FAIL loop_wrap: got req=%b addr=%0d cnt=%0d want 1 0 0", found, ifc.rd_addr, ifc.count);
        end
        total++;
        if (done_cnt != d0 || ifc.busy !== 1'b1) begin
            bad++; $display("FAIL loop_no_done: got pulses=%0d busy=%b want 0 1", done_cnt - d0, ifc.busy);
        end
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ifc.slot === 4'd2 && ifc.bit_valid === 1'b1) begin found = 1'b1; break; end
            step();
        end
        ifc.loop_en = 1'b0;
        wait_done(100, to);
        total++;
        if (!found || to || ifc.count !== 8'd23) begin
            bad++; $display("FAIL loop_exit: got found=%b to=%b cnt=%0d want 1 0 23", found, to, ifc.count);
        end
        step();
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL loop_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_hold();
        int d0;
        int herr;
        bit to;
        d0 = done_cnt; herr = 0;
        pulse_start(4'd0, 1'b0);
        step();
        repeat (9) step();
        total++;
        if (ifc.count !== 8'd2 || ifc.bit_valid !== 1'b1) begin
            bad++; $display("FAIL hold_pre: got cnt=%0d v=%b want 2 1", ifc.count, ifc.bit_valid);
        end
        ifc.hold = 1'b1;
        repeat (10) begin
            step();
            if (ifc.count !== 8'd2 || ifc.bit_out !== 1'b1) herr++;
        end
        ifc.hold = 1'b0;
        total++;
        if (herr != 0) begin bad++; $display("FAIL hold_frozen: got %0d changes want 0", herr); end
        step();
        step();
        total++;
        if (ifc.count !== 8'd2) begin bad++; $display("FAIL hold_remaining: got cnt=%0d want 2", ifc.count); end
        step();
        total++;
        if (ifc.count !== 8'd3 || ifc.bit_out !== 1'b0) begin
            bad++; $display("FAIL hold_resume: got cnt=%0d b=%b want 3 0", ifc.count, ifc.bit_out);
        end
        wait_done(100, to);
        step();
        total++;
        if (to || done_cnt - d0 != 1) begin bad++; $display("FAIL hold_done: got to=%b pulses=%0d want 0 1", to, done_cnt - d0); end
    endtask

    task automatic test_stop_ack();
        int d0;
        int verr;
        d0 = done_cnt; verr = 0;
        rom_en = 1'b0;
        pulse_start(4'd3, 1'b0);
        total++;
        if (ifc.rd_req !== 1'b1) begin bad++; $display("FAIL stop_pre: got req=%b want 1", ifc.rd_req); end
        man_ack = 1'b1; man_data = 8'hFF; ifc.stop = 1'b1;
        step();
        man_ack = 1'b0; ifc.stop = 1'b0;
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL stop_ack_idle: got %0h want 0", outs()); end
        repeat (3) begin
            step();
            if (ifc.bit_valid !== 1'b0 || ifc.busy !== 1'b0) verr++;
        end
        total++;
        if (verr != 0 || done_cnt != d0) begin
            bad++; $display("FAIL stop_no_bits: got err=%0d pulses=%0d want 0 0", verr, done_cnt - d0);
        end
        rom_en = 1'b1;
    endtask

    task automatic test_start_stop();
        ifc.last_slot = 4'd5; ifc.start = 1'b1; ifc.stop = 1'b1;
        step();
        ifc.start = 1'b0; ifc.stop = 1'b0;
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL start_stop_1: got %0h want 0", outs()); end
        step();
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL start_stop_2: got %0h want 0", outs()); end
    endtask

    task automatic test_start_busy();
        int d0;
        bit to;
        d0 = done_cnt;
        pulse_start(4'd1, 1'b0);
        step();
        repeat (3) step();
        ifc.last_slot = 4'd0; ifc.start = 1'b1;
        step();
        ifc.start = 1'b0;
        total++;
        if (ifc.bit_valid !== 1'b1 || ifc.busy !== 1'b1 || ifc.dbg_state !== 2'd2 || ifc.count !== 8'd1) begin
            bad++; $display("FAIL busy_start_state: got v=%b busy=%b st=%0d cnt=%0d want 1 1 2 1",
                            ifc.bit_valid, ifc.busy, ifc.dbg_state, ifc.count);
        end
        wait_done(200, to);
        total++;
        if (to || ifc.count !== 8'd15) begin bad++; $display("FAIL busy_start_last: got to=%b cnt=%0d want 0 15", to, ifc.count); end
        step();
        total++;
        if (done_cnt - d0 != 1) begin bad++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid_shift();
        int d0;
        d0 = done_cnt;
        pulse_start(4'd0, 1'b0);
        step();
        repeat (5) step();
        total++;
        if (ifc.bit_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_pre: got v=%b want 1", ifc.bit_valid); end
        rst_n = 1'b0;
        #1;
        total++;
        if (outs() !== 23'd0) begin bad++; $display("FAIL rst_mid_async: got %0h want 0", outs()); end
        step();
        rst_n = 1'b1;
        repeat (40) step();
        total++;
        if (done_cnt != d0 || outs() !== 23'd0) begin
            bad++; $display("FAIL rst_mid_after: got pulses=%0d outs=%0h want 0 0", done_cnt - d0, outs());
        end
    endtask

    initial begin
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.hold = 1'b0;
        ifc.loop_en = 1'b0; ifc.last_slot = 4'd0;
        test_reset();
        test_single_slot();
        test_full_run();
        test_ack_delay();
        test_loop();
        test_hold();
        test_stop_ack();
        test_start_stop();
        test_start_busy();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
